// File: rtl/nios_pio_stream_rx.sv
// nios_pio_stream_rx
// Receives 16-bit words from the NIOS software PIO channel using a 4-phase
// req/ack handshake. Each word is queued, with a last flag, into a show-ahead
// FIFO that hardware consumers drain as a valid/ready stream. The ack and
// FIFO-full status go back to software on to_sw_sig.
//
// Request codes on to_hw_sig (after synchronisation):
//   00 idle, 01 data, 11 data+last, 10 flush.
//
// Timing: ack and the word capture are registered SYNC_STAGES edges after
// the first edge that samples a new request. The captured word is written
// into FIFO storage on the following edge, so an empty FIFO shows the word
// on m_valid/m_data one edge after ack rises.
module nios_pio_stream_rx #(
   parameter int DATA_W      = 16,
   parameter int DEPTH       = 16,
   parameter int SYNC_STAGES = 2
) (
   input  logic                      clk,
   input  logic                      reset_n,
   input  logic [DATA_W-1:0]         to_hw_port,
   input  logic [1:0]                to_hw_sig,
   output logic [1:0]                to_sw_sig,
   output logic [DATA_W-1:0]         m_data,
   output logic                      m_last,
   output logic                      m_valid,
   input  logic                      m_ready,
   output logic [$clog2(DEPTH):0]    fill_level,
   output logic [15:0]               word_count
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;

   // Handshake FSM encoding
   localparam logic [1:0] ST_IDLE     = 2'd0;
   localparam logic [1:0] ST_STALL    = 2'd1;
   localparam logic [1:0] ST_FLUSH    = 2'd2;
   localparam logic [1:0] ST_ACK_WAIT = 2'd3;

   // Request codes
   localparam logic [1:0] REQ_IDLE  = 2'b00;
   localparam logic [1:0] REQ_FLUSH = 2'b10;

   // ------------------------------------------------------------------
   // Request synchroniser
   // ------------------------------------------------------------------
   logic [1:0] sync_q [SYNC_STAGES];
   logic [1:0] req_s;

   // Shift the software request through the synchroniser chain
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < SYNC_STAGES; i++) begin
            sync_q[i] <= 2'b00;
         end
      end else begin
         sync_q[0] <= to_hw_sig;
         for (int i = 1; i < SYNC_STAGES; i++) begin
            sync_q[i] <= sync_q[i-1];
         end
      end
   end

   assign req_s = sync_q[SYNC_STAGES-1];

   // ------------------------------------------------------------------
   // FIFO state
   // ------------------------------------------------------------------
   logic [DATA_W:0]  mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic [CNT_W-1:0] count;
   logic [CNT_W-1:0] count_next;
   logic             full;
   logic             full_q;
   logic             push;
   logic             pop;

   // ------------------------------------------------------------------
   // Handshake FSM state
   // ------------------------------------------------------------------
   logic [1:0]       state;
   logic [1:0]       state_next;
   logic             ack_q;
   logic             ack_next;
   logic             accept;
   logic             flush_now;
   logic             wr_pend;
   logic [DATA_W:0]  wr_word;

   assign full = (count == CNT_W'(DEPTH));

   // Decide the next handshake state, whether to take a word, and whether
   // to clear the FIFO this cycle
   always_comb begin
      state_next = state;
      ack_next   = ack_q;
      accept     = 1'b0;
      flush_now  = 1'b0;
      case (state)
         ST_IDLE: begin
            if (req_s[0]) begin
               if (!full) begin
                  accept     = 1'b1;
                  ack_next   = 1'b1;
                  state_next = ST_ACK_WAIT;
               end else begin
                  state_next = ST_STALL;
               end
            end else if (req_s == REQ_FLUSH) begin
               state_next = ST_FLUSH;
            end
         end
         ST_STALL: begin
            // A flush request overrides a word that is waiting for space;
            // a request withdrawn by software drops back to idle
            if (req_s == REQ_FLUSH) begin
               state_next = ST_FLUSH;
            end else if (req_s == REQ_IDLE) begin
               state_next = ST_IDLE;
            end else if (!full) begin
               accept     = 1'b1;
               ack_next   = 1'b1;
               state_next = ST_ACK_WAIT;
            end
         end
         ST_FLUSH: begin
            flush_now  = 1'b1;
            ack_next   = 1'b1;
            state_next = ST_ACK_WAIT;
         end
         ST_ACK_WAIT: begin
            if (req_s == REQ_IDLE) begin
               ack_next   = 1'b0;
               state_next = ST_IDLE;
            end
         end
         default: begin
            ack_next   = 1'b0;
            state_next = ST_IDLE;
         end
      endcase
   end

   // Register FSM state, ack, the word counter and the captured word
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state      <= ST_IDLE;
         ack_q      <= 1'b0;
         word_count <= 16'h0000;
         wr_pend    <= 1'b0;
         wr_word    <= '0;
      end else begin
         state   <= state_next;
         ack_q   <= ack_next;
         wr_pend <= accept;
         if (accept) begin
            wr_word <= {req_s[1], to_hw_port};
         end
         if (flush_now) begin
            word_count <= 16'h0000;
         end else if (accept) begin
            word_count <= word_count + 16'h0001;
         end
      end
   end

   // ------------------------------------------------------------------
   // FIFO datapath
   // ------------------------------------------------------------------
   // The FSM never captures a word while the FIFO is full, and the write
   // lands one edge after capture while the FSM sits in ACK_WAIT, so the
   // write below always has a free slot.
   assign push = wr_pend;
   assign pop  = m_valid & m_ready;

   // Next occupancy; a flush clears everything and ignores a same-cycle pop
   always_comb begin
      count_next = count;
      if (flush_now) begin
         count_next = '0;
      end else begin
         case ({push, pop})
            2'b10:   count_next = count + CNT_W'(1);
            2'b01:   count_next = count - CNT_W'(1);
            default: count_next = count;
         endcase
      end
   end

   // Update storage, pointers, occupancy and the registered full flag
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem[i] <= '0;
         end
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
         full_q <= 1'b0;
      end else begin
         count  <= count_next;
         full_q <= (count_next == CNT_W'(DEPTH));
         if (flush_now) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
         end else begin
            if (push) begin
               mem[wr_ptr] <= wr_word;
               wr_ptr      <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
               rd_ptr <= rd_ptr + PTR_W'(1);
            end
         end
      end
   end

   // ------------------------------------------------------------------
   // Outputs
   // ------------------------------------------------------------------
   assign m_valid    = (count != '0);
   assign m_data     = mem[rd_ptr][DATA_W-1:0];
   assign m_last     = mem[rd_ptr][DATA_W];
   assign fill_level = count;
   assign to_sw_sig  = {full_q, ack_q};

endmodule

// File: tb/tb_nios_pio_stream_rx.sv
// Testbench for nios_pio_stream_rx: directed scenarios plus randomized
// traffic, checked through a scoreboard queue of expected {last, data}
// entries that a negedge monitor pops whenever the stream handshakes.
module tb_nios_pio_stream_rx;

   localparam int DATA_W = 16;
   localparam int DEPTH  = 16;

   logic              clk;
   logic              reset_n;
   logic [DATA_W-1:0] to_hw_port;
   logic [1:0]        to_hw_sig;
   logic [1:0]        to_sw_sig;
   logic [DATA_W-1:0] m_data;
   logic              m_last;
   logic              m_valid;
   logic              m_ready;
   logic [4:0]        fill_level;
   logic [15:0]       word_count;

   int                checks;
   int                failures;
   logic [DATA_W:0]   sb [$];
   logic [15:0]       wc_model;
   logic              rand_en;

   nios_pio_stream_rx #(
      .DATA_W(DATA_W),
      .DEPTH(DEPTH),
      .SYNC_STAGES(2)
   ) dut (
      .clk(clk),
      .reset_n(reset_n),
      .to_hw_port(to_hw_port),
      .to_hw_sig(to_hw_sig),
      .to_sw_sig(to_sw_sig),
      .m_data(m_data),
      .m_last(m_last),
      .m_valid(m_valid),
      .m_ready(m_ready),
      .fill_level(fill_level),
      .word_count(word_count)
   );

   // Free-running clock
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Compare one observed value against the expected value
   task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("[TB] FAIL %s actual=0x%0h required=0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Scoreboard monitor: every accepted stream beat must match the oldest expected word
   always @(negedge clk) begin
      if (reset_n && m_valid && m_ready) begin
         if (sb.size() == 0) begin
            checks++;
            failures++;
            $display("[TB] FAIL stream_unexpected actual=0x%0h required=no_word at %0t", {m_last, m_data}, $time);
         end else begin
            check_output("stream_word", 32'({m_last, m_data}), 32'(sb.pop_front()));
         end
      end
   end

   // Drive a new request just after a rising edge
   task automatic apply_stimulus(input logic [DATA_W-1:0] d, input logic [1:0] s);
      @(posedge clk);
      #1;
      to_hw_port = d;
      to_hw_sig  = s;
   endtask

   // Wait (bounded) for ack to reach a level; m_ready may be randomized meanwhile
   task automatic wait_ack(input logic level, input int max_cycles, input string name);
      int n;
      n = 0;
      while (n < max_cycles) begin
         @(posedge clk);
         #1;
         if (rand_en) m_ready = 1'($urandom_range(0, 1));
         @(negedge clk);
         if (to_sw_sig[0] == level) break;
         n++;
      end
      check_output(name, 32'(to_sw_sig[0]), 32'(level));
   endtask

   // Complete software handshake for one word
   task automatic send_word(input logic [DATA_W-1:0] d, input logic last);
      apply_stimulus(d, {last, 1'b1});
      sb.push_back({last, d});
      wc_model = wc_model + 16'h0001;
      wait_ack(1'b1, 300, "send_ack_rise");
      apply_stimulus(d, 2'b00);
      wait_ack(1'b0, 300, "send_ack_fall");
   endtask

   // Let the consumer take everything and confirm nothing is left
   task automatic drain(input string name);
      int n;
      m_ready = 1'b1;
      n = 0;
      while (n < 200 && (m_valid || sb.size() != 0)) begin
         @(negedge clk);
         n++;
      end
      check_output({name, "_sb_empty"}, 32'(sb.size()), 32'd0);
      check_output({name, "_fill"}, 32'(fill_level), 32'd0);
      @(posedge clk);
      #1;
      m_ready = 1'b0;
   endtask

   // Watchdog so the run always ends
   initial begin
      #600000;
      $display("[TB] FAIL watchdog actual=timeout required=finish");
      $fatal(1, "[TB] watchdog expired");
   end

   // Main stimulus sequence
   initial begin
      logic [DATA_W:0] head;
      checks     = 0;
      failures   = 0;
      wc_model   = 16'h0000;
      rand_en    = 1'b0;
      reset_n    = 1'b0;
      to_hw_port = '0;
      to_hw_sig  = 2'b00;
      m_ready    = 1'b0;

      // Reset values
      #3;
      check_output("reset_to_sw_sig", 32'(to_sw_sig), 32'd0);
      check_output("reset_m_valid", 32'(m_valid), 32'd0);
      check_output("reset_m_data", 32'(m_data), 32'd0);
      check_output("reset_fill", 32'(fill_level), 32'd0);
      check_output("reset_word_count", 32'(word_count), 32'd0);
      #19;
      reset_n = 1'b1;

      // Single word with latency checks
      $display("[TB] single word");
      apply_stimulus(16'hA5C3, 2'b01);
      sb.push_back({1'b0, 16'hA5C3});
      wc_model = wc_model + 16'h0001;
      repeat (3) @(negedge clk);
      check_output("single_ack_early", 32'(to_sw_sig[0]), 32'd0);
      @(negedge clk);
      check_output("single_ack_rise", 32'(to_sw_sig[0]), 32'd1);
      check_output("single_valid_early", 32'(m_valid), 32'd0);
      @(negedge clk);
      head = sb[0];
      check_output("single_valid", 32'(m_valid), 32'd1);
      check_output("single_data", 32'(m_data), 32'(head[DATA_W-1:0]));
      check_output("single_last", 32'(m_last), 32'(head[DATA_W]));
      apply_stimulus(16'hA5C3, 2'b00);
      repeat (3) @(negedge clk);
      check_output("single_ack_hold", 32'(to_sw_sig[0]), 32'd1);
      @(negedge clk);
      check_output("single_ack_fall", 32'(to_sw_sig[0]), 32'd0);
      check_output("single_word_count", 32'(word_count), 32'(wc_model));
      drain("single");

      // Last flag ordering
      $display("[TB] last flag");
      m_ready = 1'b1;
      send_word(16'h0001, 1'b0);
      send_word(16'h0002, 1'b0);
      send_word(16'h0003, 1'b1);
      drain("last");
      check_output("last_word_count", 32'(word_count), 32'(wc_model));

      // Full and stall
      $display("[TB] full and stall");
      m_ready = 1'b0;
      for (int i = 0; i < DEPTH; i++) send_word(16'h1000 + 16'(i), 1'b0);
      repeat (2) @(negedge clk);
      check_output("full_flag", 32'(to_sw_sig[1]), 32'd1);
      check_output("full_fill", 32'(fill_level), 32'(DEPTH));
      apply_stimulus(16'h2017, 2'b11);
      sb.push_back({1'b1, 16'h2017});
      wc_model = wc_model + 16'h0001;
      repeat (8) @(negedge clk);
      check_output("stall_no_ack", 32'(to_sw_sig[0]), 32'd0);
      check_output("stall_word_count", 32'(word_count), 32'(wc_model - 16'h0001));
      @(posedge clk);
      #1;
      m_ready = 1'b1;
      @(posedge clk);
      #1;
      m_ready = 1'b0;
      wait_ack(1'b1, 20, "stall_ack_rise");
      repeat (3) @(negedge clk);
      head = sb[0];
      check_output("stall_fill", 32'(fill_level), 32'(DEPTH));
      check_output("stall_full_flag", 32'(to_sw_sig[1]), 32'd1);
      check_output("stall_head", 32'(m_data), 32'(head[DATA_W-1:0]));
      check_output("stall_word_count_after", 32'(word_count), 32'(wc_model));
      apply_stimulus(16'h2017, 2'b00);
      wait_ack(1'b0, 20, "stall_ack_fall");
      drain("stall");

      // Flush while the consumer is draining
      $display("[TB] flush");
      for (int i = 0; i < 5; i++) send_word(16'h3000 + 16'(i), 1'(i == 4));
      apply_stimulus(16'h0000, 2'b10);
      m_ready = 1'b1;
      wait_ack(1'b1, 20, "flush_ack_rise");
      sb.delete();
      wc_model = 16'h0000;
      check_output("flush_fill", 32'(fill_level), 32'd0);
      check_output("flush_valid", 32'(m_valid), 32'd0);
      check_output("flush_word_count", 32'(word_count), 32'(wc_model));
      apply_stimulus(16'h0000, 2'b00);
      wait_ack(1'b0, 20, "flush_ack_fall");
      m_ready = 1'b0;
      send_word(16'h4444, 1'b0);
      send_word(16'h5555, 1'b1);
      drain("post_flush");

      // Simultaneous push and pop
      $display("[TB] push and pop together");
      for (int i = 0; i < 3; i++) send_word(16'h6000 + 16'(i), 1'b0);
      apply_stimulus(16'h6003, 2'b01);
      sb.push_back({1'b0, 16'h6003});
      wc_model = wc_model + 16'h0001;
      repeat (3) @(posedge clk);
      #1;
      m_ready = 1'b1;
      @(negedge clk);
      check_output("pushpop_fill_before", 32'(fill_level), 32'd3);
      @(negedge clk);
      check_output("pushpop_fill_same", 32'(fill_level), 32'd3);
      @(negedge clk);
      check_output("pushpop_fill_after", 32'(fill_level), 32'd2);
      apply_stimulus(16'h6003, 2'b00);
      wait_ack(1'b0, 20, "pushpop_ack_fall");
      drain("pushpop");

      // Reset in the middle of a handshake
      $display("[TB] reset mid-handshake");
      apply_stimulus(16'h5A5A, 2'b01);
      wait_ack(1'b1, 20, "rst_ack_rise");
      #2;
      reset_n = 1'b0;
      #1;
      sb.delete();
      wc_model = 16'h0000;
      check_output("rst_to_sw_sig", 32'(to_sw_sig), 32'd0);
      check_output("rst_valid", 32'(m_valid), 32'd0);
      check_output("rst_data", 32'(m_data), 32'd0);
      check_output("rst_fill", 32'(fill_level), 32'd0);
      check_output("rst_word_count", 32'(word_count), 32'd0);
      repeat (2) @(posedge clk);
      #3;
      reset_n = 1'b1;
      sb.push_back({1'b0, 16'h5A5A});
      wc_model = 16'h0001;
      wait_ack(1'b1, 20, "rst_reaccept_ack");
      @(negedge clk);
      check_output("rst_reaccept_count", 32'(word_count), 32'(wc_model));
      apply_stimulus(16'h5A5A, 2'b00);
      wait_ack(1'b0, 20, "rst_ack_fall");
      drain("rst");

      // Randomized traffic with a randomly stalling consumer
      $display("[TB] random traffic");
      rand_en = 1'b1;
      for (int i = 0; i < 40; i++) begin
         send_word(16'($urandom), 1'($urandom_range(0, 1)));
      end
      rand_en = 1'b0;
      check_output("random_word_count", 32'(word_count), 32'(wc_model));
      drain("random");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/nios_pio_stream_rx.md
Name: nios_pio_stream_rx

Overview:
- Downstream consumer of the NIOS system's software-to-hardware PIO channel (to_hw_port, to_hw_sig, to_sw_sig).
- Runs a 4-phase req/ack handshake with software and pushes each received 16-bit word, with a last flag, into an internal FIFO.
- Presents FIFO contents as a valid/ready stream to hardware consumers such as SD-card data sinks.
- Reports ack and FIFO-full status back to software.

Parameters:
- DATA_W, 16, word width; equals the to_hw_port width.
- DEPTH, 16, FIFO depth in words; power of 2, minimum 2.
- SYNC_STAGES, 2, synchronizer flops on to_hw_sig; minimum 2.

Ports:
- clk  in  1  system clock (same domain as the NIOS PIO).
- reset_n  in  1  asynchronous active-low reset.
- to_hw_port  in  DATA_W  word from software; held stable by SW from sig assertion until ack.
- to_hw_sig  in  2  SW request: 00 idle, 01 data, 11 data+last, 10 flush.
- to_sw_sig  out  2  [0] ack, [1] FIFO full.
- m_data  out  DATA_W  stream data (FIFO head).
- m_last  out  1  last flag of the head word.
- m_valid  out  1  FIFO not empty.
- m_ready  in  1  consumer accepts head when m_valid & m_ready.
- fill_level  out  clog2(DEPTH)+1  words in FIFO.
- word_count  out  16  words accepted since reset or flush; wraps 0xFFFF->0x0000.

Behaviour:
- Reset values (async assert, sync release): to_sw_sig=00, m_valid=0, m_data=0, m_last=0, fill_level=0, word_count=0, FSM=IDLE, FIFO pointers=0, sync flops=00.
- to_hw_sig passes through SYNC_STAGES flops; only the synchronized value (req_s) is decoded.
- to_hw_port is sampled unsynchronized at the write cycle. SW guarantees stability, so it needs no synchronizer.
- FSM states:
  - IDLE:
    - req_s=01/11 and FIFO not full -> push {port, req_s[1]}, set ack=1, word_count+1, go ACK_WAIT.
    - req_s=01/11 and FIFO full -> go STALL. No push, ack stays 0.
    - req_s=10 -> go FLUSH.
    - req_s=00 -> stay.
  - STALL:
    - FIFO not full (pop freed space) -> push, ack=1, word_count+1, go ACK_WAIT.
    - req_s=10 -> go FLUSH; flush has priority.
  - FLUSH: one cycle. Pointers and fill_level=0, m_valid=0, word_count=0. Any same-cycle pop is ignored. ack=1, go ACK_WAIT.
  - ACK_WAIT: hold ack=1 until req_s=00, then ack=0 and go IDLE. A new nonzero request is not honoured until req_s has been seen at 00.
- Latency:
  - First clock edge sampling a new to_hw_sig = edge k.
  - ack and the FIFO push are registered at edge k+SYNC_STAGES (k+2 by default).
  - The pushed word appears on m_data/m_valid at edge k+SYNC_STAGES+1 if the FIFO was empty.
  - ack falls SYNC_STAGES edges after SW clears sig.
- FIFO:
  - Show-ahead; m_data/m_last are driven from the head entry (registered read pointer).
  - Pop on m_valid & m_ready.
  - Push and pop in the same cycle: allowed when not full; fill_level unchanged.
  - Push into a full FIFO never occurs, because the FSM gates it. No pass-through: a pop while full frees a slot only from the next cycle.
  - Pointers are clog2(DEPTH) bits and wrap naturally.
  - to_sw_sig[1] = (fill_level==DEPTH), registered.
- Data held on m_data with m_valid=1 and m_ready=0 stays stable indefinitely.
- Reset mid-handshake: ack drops immediately. If SW still holds 01/11 after reset release, the block treats it as a new word, so SW must re-sync by clearing sig.
- Illegal/transitional sync values (e.g. 01->11 glitch): none are possible, because SW writes sig atomically. The FSM decodes whatever value it first sees leaving 00.

Test Plan:
- Single word: port=0xA5C3, sig 00->01; after 2 cycles ack=1, then m_valid=1, m_data=0xA5C3, m_last=0; SW clears sig -> ack=0 two cycles later; word_count=1.
- Last flag: send 0x0001(01), 0x0002(01), 0x0003(11) with m_ready=1 -> stream 1,2,3 in order; m_last=1 only on 0x0003; word_count=3.
- Full/stall: m_ready=0, send DEPTH=16 words -> to_sw_sig[1]=1. Send a 17th word -> ack stays 0. Pulse m_ready one cycle -> 17th word is pushed, ack=1, fill_level stays 16, head = word 2.
- Flush: 5 words queued, sig=10 while m_ready=1 -> fill_level=0, m_valid=0, word_count=0, ack=1; earlier entries never reappear.
- Simultaneous push/pop: FIFO at 3, m_ready=1 continuous, push a word -> fill_level stays 3 on the push cycle; order is preserved.
- Reset mid-handshake: assert reset_n=0 while ack=1 -> all outputs at reset values asynchronously; release with sig=01 -> block re-accepts the word (word_count=1).
